// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared types and defaults for the flash-to-codec audio
//                playback path (fetch/playback state encodings, FIFO depth).
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    // Default sample FIFO depth in 16-bit entries (power of two, >= 4)
    localparam int c_fifo_depth_default = 8;

    // Flash fetch state machine
    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2
    } fetch_state_t;

    // Codec playback state machine
    typedef enum logic [0:0] {
        P_IDLE  = 1'b0,
        P_WRITE = 1'b1
    } play_state_t;

endpackage
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sample_fifo
//  Description : 16-bit sample FIFO that accepts two entries per push (low
//                half then high half of a flash word) and releases one entry
//                per pop. Head entry is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH = c_fifo_depth_default
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push2,
    input  logic [15:0]            push_lo,
    input  logic [15:0]            push_hi,
    input  logic                   pop,
    output logic [15:0]            pop_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [15:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic [c_aw-1:0] w_wr_ptr_p1;

    // Depth is a power of two, so pointer arithmetic wraps for free
    assign w_wr_ptr_p1 = r_wr_ptr + c_aw'(1);

    // Storage: both halves of a flash word land in consecutive slots
    always_ff @(posedge clk) begin
        if (push2) begin
            r_mem[r_wr_ptr]    <= push_lo;
            r_mem[w_wr_ptr_p1] <= push_hi;
        end
    end

    // Pointers and occupancy; a push and a pop in one cycle nets +1
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push2) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(2);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            r_count <= r_count + (push2 ? (c_aw+1)'(2) : '0) - (pop ? (c_aw+1)'(1) : '0);
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/playback_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : playback_scheduler
//  Description : Streams 16-bit audio samples from an Avalon-MM flash into a
//                codec DAC. A fetch FSM keeps the sample FIFO topped up one
//                32-bit word at a time; a playback FSM pops one sample per
//                sample_tick and handshakes it into the codec.
//  Revision    : 1.0 - initial release
// ============================================================================
module playback_scheduler
    import audio_pkg::*;
#(
    parameter logic [22:0] START_ADDR = 23'h000000,
    parameter logic [22:0] END_ADDR   = 23'h07FFFF,
    parameter int          FIFO_DEPTH = c_fifo_depth_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic        start,
    input  logic        pause,
    output logic        flash_mem_read,
    output logic [22:0] flash_mem_address,
    output logic [3:0]  flash_mem_byteenable,
    input  logic        flash_mem_waitrequest,
    input  logic [31:0] flash_mem_readdata,
    input  logic        flash_mem_readdatavalid,
    input  logic        codec_write_ready,
    output logic        codec_write,
    output logic [15:0] codec_data,
    output logic        playing,
    output logic        underrun
);

    localparam int c_cw = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    r_fetch_state;
    fetch_state_t    w_fetch_next;
    play_state_t     r_play_state;
    play_state_t     w_play_next;
    logic [22:0]     r_addr;
    logic            r_abort;       // start dropped while a transaction was in flight
    logic [15:0]     r_codec_data;
    logic            r_underrun;
    logic            w_playing;
    logic            w_flush;
    logic            w_avail;
    logic            w_tick_ok;
    logic            w_pop;
    logic            w_push;
    logic            w_fetch_go;
    logic [15:0]     w_fifo_data;
    logic [c_cw-1:0] w_count;
    logic [c_cw:0]   w_free;

    assign w_playing  = start & ~pause;
    // Rewind only once the bus is quiet, so an in-flight word is never half-kept
    assign w_flush    = (r_fetch_state == F_IDLE) && (!start || r_abort);
    assign w_avail    = (w_count != '0) && !w_flush;
    assign w_tick_ok  = (r_play_state == P_IDLE) && sample_tick && w_playing;
    assign w_pop      = w_tick_ok && w_avail;
    // Free space counts an entry leaving this very cycle
    assign w_free     = (c_cw+1)'(FIFO_DEPTH) - {1'b0, w_count} + {{c_cw{1'b0}}, w_pop};
    assign w_fetch_go = start && (w_free >= (c_cw+1)'(2));
    assign w_push     = (r_fetch_state == F_WAIT) && flash_mem_readdatavalid && start && !r_abort;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (w_flush),
        .push2    (w_push),
        .push_lo  (flash_mem_readdata[15:0]),
        .push_hi  (flash_mem_readdata[31:16]),
        .pop      (w_pop),
        .pop_data (w_fifo_data),
        .count    (w_count)
    );

    // State registers for both FSMs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_state <= F_IDLE;
            r_play_state  <= P_IDLE;
        end else begin
            r_fetch_state <= w_fetch_next;
            r_play_state  <= w_play_next;
        end
    end

    // Fetch FSM: one single-word read outstanding at a time
    always_comb begin
        w_fetch_next = r_fetch_state;
        case (r_fetch_state)
            F_IDLE:  if (w_fetch_go)               w_fetch_next = F_REQ;
            F_REQ:   if (!flash_mem_waitrequest)   w_fetch_next = F_WAIT;
            F_WAIT:  if (flash_mem_readdatavalid)  w_fetch_next = F_IDLE;
            default:                               w_fetch_next = F_IDLE;
        endcase
    end

    // Playback FSM: hold the write strobe until the codec takes the sample
    always_comb begin
        w_play_next = r_play_state;
        case (r_play_state)
            P_IDLE:  if (w_pop)             w_play_next = P_WRITE;
            P_WRITE: if (codec_write_ready) w_play_next = P_IDLE;
            default:                        w_play_next = P_IDLE;
        endcase
    end

    // Address, abort tracking, output sample and underrun pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= START_ADDR;
            r_abort      <= 1'b0;
            r_codec_data <= '0;
            r_underrun   <= 1'b0;
        end else begin
            r_underrun <= w_tick_ok && !w_avail;
            if (w_pop) begin
                r_codec_data <= w_fifo_data;
            end
            if (w_flush) begin
                r_addr <= START_ADDR;
            end else if (w_push) begin
                r_addr <= (r_addr == END_ADDR) ? START_ADDR : r_addr + 23'd1;
            end
            if (r_fetch_state == F_IDLE) begin
                r_abort <= 1'b0;
            end else if (!start) begin
                r_abort <= 1'b1;
            end
        end
    end

    // Outputs are forced quiet while reset is held, even mid-transaction
    assign flash_mem_read       = !reset && (r_fetch_state == F_REQ);
    assign flash_mem_address    = reset ? START_ADDR : r_addr;
    assign flash_mem_byteenable = 4'hF;
    assign codec_write          = !reset && (r_play_state == P_WRITE);
    assign codec_data           = reset ? 16'h0000 : r_codec_data;
    assign playing              = !reset && w_playing;
    assign underrun             = !reset && r_underrun;

endmodule
`default_nettype wire

// File: doc/playback_scheduler.md
PLAYBACK_SCHEDULER -- requirements
Module: playback_scheduler

Interface
REQ-001 Parameter START_ADDR, default 23'h000000, first flash word address of the audio image.
REQ-002 Parameter END_ADDR, default 23'h07FFFF, last flash word address; the next address after it is START_ADDR.
REQ-003 Parameter FIFO_DEPTH, default 8, sample FIFO depth (16-bit entries, power of two, >=4).
REQ-004 clk  in  1  50 MHz system clock; all logic is on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sample_tick  in  1  one-clk pulse per audio sample period, already synchronized and edge-detected.
REQ-007 start  in  1  level; 1 = run, 0 = stop and rewind.
REQ-008 pause  in  1  level; 1 = hold playback position.
REQ-009 flash_mem_read  out  1  Avalon-MM read request.
REQ-010 flash_mem_address  out  23  Avalon-MM word address.
REQ-011 flash_mem_byteenable  out  4  byte enables, constant 4'hF.
REQ-012 flash_mem_waitrequest  in  1  Avalon-MM wait request.
REQ-013 flash_mem_readdata  in  32  Avalon-MM read data.
REQ-014 flash_mem_readdatavalid  in  1  Avalon-MM read data valid.
REQ-015 codec_write_ready  in  1  codec DAC FIFO can accept a sample.
REQ-016 codec_write  out  1  write strobe to codec (both channels).
REQ-017 codec_data  out  16  signed sample to codec, held stable while codec_write=1.
REQ-018 playing  out  1  1 when start=1 and pause=0.
REQ-019 underrun  out  1  one-clk pulse when a tick finds the FIFO empty.

Function
REQ-020 Fetch FSM SHALL have the states F_IDLE, F_REQ and F_WAIT.
REQ-021 F_IDLE -> F_REQ when start=1 and the FIFO has >=2 free entries, counting entries popped in the same cycle.
REQ-022 In F_REQ, flash_mem_read=1 and the address SHALL be held until a cycle with waitrequest=0; that cycle moves the FSM to F_WAIT and drops read in the next cycle.
REQ-023 In F_WAIT, on readdatavalid=1 the FSM SHALL push readdata[15:0] then readdata[31:16] (two entries in one cycle), advance the address with wrap END_ADDR->START_ADDR, and go to F_IDLE.
REQ-024 At most one flash transaction SHALL be outstanding; burst count is always 1.
REQ-025 Playback FSM SHALL have the states P_IDLE and P_WRITE.
REQ-026 P_IDLE: on sample_tick with playing=1 and FIFO non-empty, pop one entry into codec_data and go to P_WRITE.
REQ-027 P_WRITE: codec_write=1 until the first cycle with codec_write_ready=1; that is the transfer cycle, then return to P_IDLE.
REQ-028 A sample_tick that arrives while in P_WRITE SHALL be ignored; no underrun is flagged.
REQ-029 A sample_tick with playing=1 and FIFO empty in P_IDLE SHALL pulse underrun for 1 clk; no write occurs and codec_data holds its value.
REQ-030 Latency: codec_write SHALL rise in the clk after the accepted tick.
REQ-031 Push and pop in the same cycle SHALL both take effect (count +2-1); a push SHALL never be issued to a full FIFO.
REQ-032 pause=1: ticks are ignored; fetching continues until the FIFO is full; a write already in P_WRITE completes.
REQ-033 start 1->0: no new fetch is issued; any F_REQ/F_WAIT transaction SHALL complete and its data is discarded; then the FIFO is flushed and the address is reloaded to START_ADDR; a pending P_WRITE completes.
REQ-034 start=0 and pause=1 together behave as stop.

Reset
REQ-035 reset=1 SHALL force both FSMs to idle, empty the FIFO and set the address to START_ADDR, in the same clk edge even mid-transaction.
REQ-036 During reset, all outputs SHALL be 0, except byteenable=4'hF and flash_mem_address=START_ADDR.

Structure
REQ-037 Fetch and playback state enums, plus the FIFO default, SHALL live in the shared package audio_pkg.
REQ-038 The FIFO SHALL be the sub-module sample_fifo (dual-push/single-pop, count output); the FSMs stay in playback_scheduler.

Verification
REQ-039 Reset, start=1, waitrequest=1 for 3 clk then 0, readdatavalid with 32'hBBBB_AAAA -> address 0 held for 4 clk; FIFO = AAAA, BBBB.
REQ-040 Tick with codec_write_ready=0 for 5 clk -> codec_write=1 for 6 clk with codec_data=16'hAAAA; next tick -> 16'hBBBB.
REQ-041 Address at END_ADDR=23'h000003 with 4 words read -> the 5th request uses address 0.
REQ-042 Tick with FIFO empty (flash held with waitrequest=1) -> underrun=1 for 1 clk; codec_write stays 0.
REQ-043 pause=1 with 10 ticks -> no codec writes; FIFO fills to 8 and no further read is issued; pause=0 resumes with the next stored sample.
REQ-044 start->0 during F_WAIT -> data is discarded, FIFO count=0, and the next start=1 reads address START_ADDR; reset asserted during F_REQ -> read=0 in the next clk.
